// File: rtl/seq_sign_mpy_ctrl_if.sv
// Handshake bundle between a host (driver) and the sequential signed multiplier.
// start/a/b come from the host, while busy/done/product/dbg_state come from the multiplier.
interface seq_sign_mpy_ctrl_if #(
  parameter int WIDTH = 4
) ();
  // Handshake: start is accepted only on an edge where the multiplier is not busy.
  // busy stays high for WIDTH cycles, and then done pulses for one cycle while product is valid.
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [1:0]           dbg_state;

  modport master (
    output start, a, b,
    input  busy, done, product, dbg_state
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, dbg_state
  );
endinterface

// File: rtl/seq_sign_mpy_ctrl.sv
// Iterative two's-complement multiplier that adds one partial product per clock through a shared adder.
// The final (MSB) partial product is subtracted, so signed operands need no sign-extension rows.
module seq_sign_mpy_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_sign_mpy_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [WIDTH-1:0]     r_ra;
  logic [WIDTH-1:0]     r_rb;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_product;

  logic [2*WIDTH-1:0]   w_term;
  logic [WIDTH-1:0]     w_rb_sh;
  logic                 w_bit;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_next_acc;

  // The multiplicand is sign-extended to the product width before shifting, so each term is already signed.
  assign w_term  = {{WIDTH{r_ra[WIDTH-1]}}, r_ra} << r_cnt;
  assign w_rb_sh = r_rb >> r_cnt;
  assign w_bit   = w_rb_sh[0];
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_next_acc = r_acc;
    if (w_bit) begin
      if (w_last) w_next_acc = r_acc - w_term;
      else        w_next_acc = r_acc + w_term;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ra      <= '0;
      r_rb      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc <= w_next_acc;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_product <= w_next_acc;
            r_state   <= S_DONE;
          end
        end
        S_IDLE, S_DONE: begin
          // DONE accepts a new start directly, so a held start gives one operation every WIDTH+1 cycles.
          if (bus.start) begin
            r_ra    <= bus.a;
            r_rb    <= bus.b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state == S_RUN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.product   = r_product;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_seq_sign_mpy_ctrl.sv
// Directed bench for seq_sign_mpy_ctrl (WIDTH=4).
// It covers reset, the hand-computed products, a full operand sweep, ignored start, back-to-back operation and mid-run reset.
module tb_seq_sign_mpy_ctrl;

  localparam int WIDTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   done_cnt;
  int   cyc;

  seq_sign_mpy_ctrl_if #(.WIDTH(WIDTH)) bus ();

  seq_sign_mpy_ctrl #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done, up to a cycle budget, and returns the number of edges waited.
  task automatic wait_done(input bit toggle, output int n);
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (toggle) begin
        bus.a = WIDTH'($urandom_range(0, 15));
        bus.b = WIDTH'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp, input bit toggle);
    int n;
    int d0;
    d0 = done_cnt;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    wait_done(toggle, n);
    check({tag, "_lat"}, 32'(n), 32'd4);
    check({tag, "_prod"}, 32'(bus.product), 32'(exp));
    tick();
    check({tag, "_done1"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_idle"}, 32'(bus.dbg_state), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    int first_cyc;
    logic signed [7:0] e;
    n_checks = 0;
    n_pass = 0;
    done_cnt = 0;
    cyc = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_prod", 32'(bus.product), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // directed vectors
    run_op("3x-2", 4'h3, 4'hE, 8'hFA, 1'b0);
    check("hold_idle", 32'(bus.product), 32'hFA);
    run_op("-8x-8", 4'h8, 4'h8, 8'h40, 1'b0);
    run_op("-8x7", 4'h8, 4'h7, 8'hC8, 1'b0);
    run_op("7x7", 4'h7, 4'h7, 8'h31, 1'b0);
    run_op("0x-1", 4'h0, 4'hF, 8'h00, 1'b0);

    // full sweep with operands scrambled during RUN
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        e = 8'($signed(4'(i)) * $signed(4'(j)));
        run_op("sweep", 4'(i), 4'(j), e, 1'b1);
      end
    end

    // start re-asserted during RUN is ignored
    d0 = done_cnt;
    bus.a = 4'h5;
    bus.b = 4'hD;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.a = 4'h1;
    bus.b = 4'h1;
    tick();
    bus.start = 1'b0;
    wait_done(1'b0, n);
    check("ign_lat", 32'(n), 32'd2);
    check("ign_prod", 32'(bus.product), 32'hF1);
    repeat (3) tick();
    check("ign_done1", 32'(done_cnt - d0), 32'd1);

    // start held across DONE: back-to-back
    d0 = done_cnt;
    bus.a = 4'h2;
    bus.b = 4'h5;
    bus.start = 1'b1;
    tick();
    bus.a = 4'hD;
    bus.b = 4'h3;
    wait_done(1'b0, n);
    first_cyc = cyc;
    check("b2b_prod1", 32'(bus.product), 32'h0A);
    tick();
    bus.start = 1'b0;
    check("b2b_busy", 32'(bus.busy), 32'd1);
    check("b2b_hold", 32'(bus.product), 32'h0A);
    wait_done(1'b0, n);
    check("b2b_space", 32'(cyc - first_cyc), 32'd5);
    check("b2b_prod2", 32'(bus.product), 32'hF7);
    tick();
    check("b2b_done2", 32'(done_cnt - d0), 32'd2);

    // asynchronous reset mid-RUN
    d0 = done_cnt;
    bus.a = 4'h5;
    bus.b = 4'h3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    check("arst_prod", 32'(bus.product), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    check("arst_nodone", 32'(done_cnt - d0), 32'd0);
    run_op("2x3", 4'h2, 4'h3, 8'h06, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
